// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: access sizes, arbiter
// states and the alignment rule used by MEM and the arbiter.
package rv32i_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT_I,
    ARB_WAIT_D,
    ARB_MISAL
  } arb_state_e;

  // Size 11 is treated as a word access.
  function automatic logic is_misaligned(
    input logic [1:0] size,
    input logic [1:0] lsb
  );
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lsb[0];
      default: return |lsb;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side signals of the shared
// memory port, grouped for the arbiter and its environment.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [1:0]    d_size;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_misalign;

  logic          m_req;
  logic          m_we;
  logic [1:0]    m_size;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic          m_ack;
  logic [DW-1:0] m_rdata;

  modport master (
    input  if_req, if_addr,
    input  d_req, d_we, d_size,
    input  d_addr, d_wdata,
    input  m_ack, m_rdata,
    output if_gnt, if_rvalid, if_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output d_misalign,
    output m_req, m_we, m_size,
    output m_addr, m_wdata
  );

  modport slave (
    output if_req, if_addr,
    output d_req, d_we, d_size,
    output d_addr, d_wdata,
    output m_ack, m_rdata,
    input  if_gnt, if_rvalid, if_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  d_misalign,
    input  m_req, m_we, m_size,
    input  m_addr, m_wdata
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// Cycle counter for one memory transaction;
// o_tc flags the last cycle before abort.
module arb_timeout_ctr #(
  parameter int TC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int W = (TC > 1) ? $clog2(TC) : 1;

  logic [W-1:0] r_cnt;

  // Clear wins over count so a back-to-back launch restarts at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_tc = (r_cnt == W'(TC - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and MEM:
// data first, fetch starvation guard, timeout, misalign.
module mem_port_arbiter
  import rv32i_pkg::*;
#(
  parameter int AW              = 32,
  parameter int DW              = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.master bus,
  output logic               err,
  output logic               busy
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_DATA_STREAK);

  arb_state_e    r_state, w_state;
  logic [SW-1:0] r_streak, w_streak;
  logic          r_m_req, w_m_req;
  logic          r_m_we, w_m_we;
  logic [1:0]    r_m_size, w_m_size;
  logic [AW-1:0] r_m_addr, w_m_addr;
  logic [DW-1:0] r_m_wdata, w_m_wdata;
  logic          r_if_gnt, w_if_gnt;
  logic          r_if_rvalid, w_if_rvalid;
  logic [DW-1:0] r_if_rdata, w_if_rdata;
  logic          r_d_gnt, w_d_gnt;
  logic          r_d_rvalid, w_d_rvalid;
  logic [DW-1:0] r_d_rdata, w_d_rdata;
  logic          r_d_mis, w_d_mis;
  logic          r_err, w_err;
  logic          r_busy, w_busy;

  logic w_arb;
  logic w_clr;
  logic w_tc;
  logic w_waiting;
  logic w_pick_d;
  logic w_pick_i;

  assign w_waiting = (r_state == ARB_WAIT_I) ||
                     (r_state == ARB_WAIT_D);

  // Fetch takes the slot only once data has hogged it.
  assign w_pick_d = bus.d_req &&
                    !(bus.if_req && r_streak == SMAX);
  assign w_pick_i = bus.if_req && !w_pick_d;

  arb_timeout_ctr #(
    .TC(TIMEOUT)
  ) u_tmr (
    .clk  (clk),
    .rst  (reset),
    .i_clr(w_clr),
    .i_en (w_waiting),
    .o_tc (w_tc)
  );

  // Registered state and every output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_IDLE;
      r_streak    <= '0;
      r_m_req     <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_size    <= '0;
      r_m_addr    <= '0;
      r_m_wdata   <= '0;
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_d_mis     <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_streak    <= w_streak;
      r_m_req     <= w_m_req;
      r_m_we      <= w_m_we;
      r_m_size    <= w_m_size;
      r_m_addr    <= w_m_addr;
      r_m_wdata   <= w_m_wdata;
      r_if_gnt    <= w_if_gnt;
      r_if_rvalid <= w_if_rvalid;
      r_if_rdata  <= w_if_rdata;
      r_d_gnt     <= w_d_gnt;
      r_d_rvalid  <= w_d_rvalid;
      r_d_rdata   <= w_d_rdata;
      r_d_mis     <= w_d_mis;
      r_err       <= w_err;
      r_busy      <= w_busy;
    end
  end

  // Completion, timeout and arbitration/launch decisions.
  always_comb begin
    w_state     = r_state;
    w_streak    = r_streak;
    w_m_req     = r_m_req;
    w_m_we      = r_m_we;
    w_m_size    = r_m_size;
    w_m_addr    = r_m_addr;
    w_m_wdata   = r_m_wdata;
    w_if_gnt    = 1'b0;
    w_if_rvalid = 1'b0;
    w_if_rdata  = r_if_rdata;
    w_d_gnt     = 1'b0;
    w_d_rvalid  = 1'b0;
    w_d_rdata   = r_d_rdata;
    w_d_mis     = 1'b0;
    w_err       = r_err;
    w_arb       = 1'b0;
    w_clr       = 1'b0;

    case (r_state)
      ARB_IDLE: w_arb = 1'b1;
      ARB_WAIT_I, ARB_WAIT_D: begin
        if (bus.m_ack || w_tc) begin
          w_m_req = 1'b0;
          w_state = ARB_IDLE;
          w_arb   = bus.m_ack;
          w_err   = r_err | ~bus.m_ack;
          if (r_state == ARB_WAIT_I) begin
            w_if_rvalid = 1'b1;
            w_if_rdata  = bus.m_ack ? bus.m_rdata : '0;
          end else begin
            w_d_rvalid = 1'b1;
            w_d_rdata  = (bus.m_ack && !r_m_we) ?
                         bus.m_rdata : '0;
          end
        end
      end
      ARB_MISAL: begin
        w_d_rvalid = 1'b1;
        w_d_mis    = 1'b1;
        w_d_rdata  = '0;
        w_state    = ARB_IDLE;
      end
      default: w_state = ARB_IDLE;
    endcase

    if (w_arb) begin
      if (w_pick_d && bus.if_req) begin
        w_streak = (r_streak == SMAX) ?
                   r_streak : r_streak + SW'(1);
      end else begin
        w_streak = '0;
      end

      if (w_pick_d) begin
        w_d_gnt = 1'b1;
        if (is_misaligned(bus.d_size, bus.d_addr[1:0])) begin
          w_state = ARB_MISAL;
          w_m_req = 1'b0;
        end else begin
          w_state   = ARB_WAIT_D;
          w_m_req   = 1'b1;
          w_m_we    = bus.d_we;
          w_m_size  = (bus.d_size == 2'b11) ?
                      SZ_WORD : bus.d_size;
          w_m_addr  = bus.d_addr;
          w_m_wdata = bus.d_wdata;
          w_clr     = 1'b1;
        end
      end else if (w_pick_i) begin
        w_if_gnt  = 1'b1;
        w_state   = ARB_WAIT_I;
        w_m_req   = 1'b1;
        w_m_we    = 1'b0;
        w_m_size  = SZ_WORD;
        w_m_addr  = bus.if_addr;
        w_m_wdata = '0;
        w_clr     = 1'b1;
      end
    end

    w_busy = (w_state != ARB_IDLE);
  end

  assign bus.m_req      = r_m_req;
  assign bus.m_we       = r_m_we;
  assign bus.m_size     = r_m_size;
  assign bus.m_addr     = r_m_addr;
  assign bus.m_wdata    = r_m_wdata;
  assign bus.if_gnt     = r_if_gnt;
  assign bus.if_rvalid  = r_if_rvalid;
  assign bus.if_rdata   = r_if_rdata;
  assign bus.d_gnt      = r_d_gnt;
  assign bus.d_rvalid   = r_d_rvalid;
  assign bus.d_rdata    = r_d_rdata;
  assign bus.d_misalign = r_d_mis;
  assign err            = r_err;
  assign busy           = r_busy;

endmodule
